// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: advances/holds the PC, applies execute-stage redirects
// (deferred until instruction memory is ready) and raises a timed flush window.
module fetch_redirect_ctrl #(
  parameter int unsigned PC_WIDTH     = 20,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_in,
  input  logic                 imem_ready_in,
  input  logic                 redirect_valid_in,
  input  logic [PC_WIDTH-1:0]  redirect_pc_in,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 fetch_valid_out,
  output logic                 flush_out,
  output logic                 redirect_ack_out,
  output logic [CNT_WIDTH-1:0] redirect_cnt_out
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   pc_q, pc_next;
  logic [PC_WIDTH-1:0]   target_q, target_next;
  logic [FC_W-1:0]       flush_cnt, flush_cnt_next;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_next;
  logic                  do_apply;
  logic [PC_WIDTH-1:0]   apply_target;
  logic [PC_WIDTH-1:0]   pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc_q      <= PC_WIDTH'(RESET_PC);
      target_q  <= '0;
      flush_cnt <= '0;
      cnt_q     <= '0;
    end else begin
      state     <= state_next;
      pc_q      <= pc_next;
      target_q  <= target_next;
      flush_cnt <= flush_cnt_next;
      cnt_q     <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc_q;
    target_next      = target_q;
    flush_cnt_next   = flush_cnt;
    cnt_next         = cnt_q;
    fetch_valid_out  = 1'b0;
    flush_out        = 1'b0;
    redirect_ack_out = 1'b0;
    do_apply         = 1'b0;
    apply_target     = '0;

    case (state)
      RUN: begin
        if (redirect_valid_in) begin
          flush_out = 1'b1;
          if (imem_ready_in) begin
            do_apply     = 1'b1;
            apply_target = redirect_pc_in;
          end else begin
            target_next = {redirect_pc_in[PC_WIDTH-1:2], 2'b00};
            state_next  = HOLD;
          end
        end else begin
          fetch_valid_out = imem_ready_in & ~stall_in;
          if (fetch_valid_out) pc_next = pc_inc;
        end
      end
      HOLD: begin
        flush_out = 1'b1;
        if (imem_ready_in) begin
          do_apply     = 1'b1;
          apply_target = target_q;
        end
      end
      FLUSH: begin
        flush_out       = 1'b1;
        fetch_valid_out = imem_ready_in & ~stall_in;
        if (fetch_valid_out) pc_next = pc_inc;
        if (flush_cnt == '0) state_next = RUN;
        else                 flush_cnt_next = flush_cnt - FC_W'(1);
      end
      default: state_next = RUN;
    endcase

    // A single-cycle window is fully covered by the accepting cycle itself.
    if (do_apply) begin
      redirect_ack_out = 1'b1;
      pc_next          = {apply_target[PC_WIDTH-1:2], 2'b00};
      if (cnt_q != '1) cnt_next = cnt_q + CNT_WIDTH'(1);
      if (FLUSH_CYCLES <= 1) begin
        state_next = RUN;
      end else begin
        state_next     = FLUSH;
        flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
      end
    end
  end

  assign pc_out           = pc_q;
  assign redirect_cnt_out = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed table, corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_fetch_redirect_ctrl;

  localparam int PCW = 20;
  localparam logic [PCW-1:0] PC_MASK = '1;
  localparam int FLUSH_AFTER_APPLY = 2;
  localparam int SMALL_MAX = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall_in = 1'b0;
  logic            imem_ready_in = 1'b0;
  logic            redirect_valid_in = 1'b0;
  logic [PCW-1:0]  redirect_pc_in = '0;
  logic [PCW-1:0]  pc_out, pc_small;
  logic            fetch_valid_out, flush_out, redirect_ack_out;
  logic            fetch_small, flush_small, ack_small;
  logic [15:0]     redirect_cnt_out;
  logic [1:0]      cnt_small;

  int n_cmp = 0;
  int n_err = 0;

  logic [PCW-1:0] m_pc;
  logic [PCW-1:0] m_tgt;
  bit             m_pend;
  int             m_flush_left;
  int             m_cnt;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .imem_ready_in(imem_ready_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .pc_out(pc_out), .fetch_valid_out(fetch_valid_out), .flush_out(flush_out),
    .redirect_ack_out(redirect_ack_out), .redirect_cnt_out(redirect_cnt_out)
  );

  // Narrow counter instance so saturation is reachable in a few redirects.
  fetch_redirect_ctrl #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .imem_ready_in(imem_ready_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .pc_out(pc_small), .fetch_valid_out(fetch_small), .flush_out(flush_small),
    .redirect_ack_out(ack_small), .redirect_cnt_out(cnt_small)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           stall;
    logic           ready;
    logic           rv;
    logic [PCW-1:0] rpc;
    logic [PCW-1:0] exp_pc;
    logic           exp_fetch;
    logic           exp_flush;
    logic           exp_ack;
    int             exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic rv, input logic [PCW-1:0] rpc);
    stall_in          = s;
    imem_ready_in     = r;
    redirect_valid_in = rv;
    redirect_pc_in    = rpc;
    #1;
  endtask

  task automatic modelReset();
    m_pc = '0; m_tgt = '0; m_pend = 0; m_flush_left = 0; m_cnt = 0;
  endtask

  // Compare against the model for the current cycle, advance it, go to next negedge.
  task automatic stepModel();
    logic e_fetch, e_flush, e_ack;
    logic s, r, rv;
    s = stall_in; r = imem_ready_in; rv = redirect_valid_in;
    e_fetch = 0; e_flush = 0; e_ack = 0;
    checkOutput("pc", 32'(pc_out), 32'(m_pc));
    checkOutput("cnt", 32'(redirect_cnt_out), 32'(m_cnt));
    checkOutput("cnt_small", 32'(cnt_small), 32'((m_cnt > SMALL_MAX) ? SMALL_MAX : m_cnt));
    if (m_pend) begin
      e_flush = 1;
      if (r) begin
        e_ack = 1; m_pc = m_tgt; m_pend = 0; m_cnt++; m_flush_left = FLUSH_AFTER_APPLY;
      end
    end else if (m_flush_left > 0) begin
      e_flush = 1;
      e_fetch = r & ~s;
      if (e_fetch) m_pc = (m_pc + 4) & PC_MASK;
      m_flush_left--;
    end else if (rv) begin
      e_flush = 1;
      if (r) begin
        e_ack = 1; m_pc = redirect_pc_in & ~PCW'(3); m_cnt++; m_flush_left = FLUSH_AFTER_APPLY;
      end else begin
        m_pend = 1; m_tgt = redirect_pc_in & ~PCW'(3);
      end
    end else begin
      e_fetch = r & ~s;
      if (e_fetch) m_pc = (m_pc + 4) & PC_MASK;
    end
    checkOutput("fetch", 32'(fetch_valid_out), 32'(e_fetch));
    checkOutput("flush", 32'(flush_out), 32'(e_flush));
    checkOutput("ack", 32'(redirect_ack_out), 32'(e_ack));
    @(negedge clk);
  endtask

  task automatic addVec(input logic s, input logic r, input logic rv, input logic [PCW-1:0] rpc,
                        input logic [PCW-1:0] pc, input logic f, input logic fl, input logic a, input int c);
    vec_t v;
    v.stall = s; v.ready = r; v.rv = rv; v.rpc = rpc;
    v.exp_pc = pc; v.exp_fetch = f; v.exp_flush = fl; v.exp_ack = a; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    //     stall rdy rv  target     pc       fet fl  ack cnt
    addVec(0, 1, 0, 20'h0,     20'h00000, 1, 0, 0, 0);
    addVec(0, 1, 0, 20'h0,     20'h00004, 1, 0, 0, 0);
    addVec(0, 1, 0, 20'h0,     20'h00008, 1, 0, 0, 0);
    addVec(0, 1, 0, 20'h0,     20'h0000C, 1, 0, 0, 0);
    addVec(0, 1, 1, 20'h200,   20'h00010, 0, 1, 1, 0);
    addVec(0, 1, 0, 20'h0,     20'h00200, 1, 1, 0, 1);
    addVec(0, 1, 0, 20'h0,     20'h00204, 1, 1, 0, 1);
    addVec(0, 1, 0, 20'h0,     20'h00208, 1, 0, 0, 1);
    addVec(0, 0, 1, 20'h400,   20'h0020C, 0, 1, 0, 1);
    addVec(0, 0, 0, 20'h0,     20'h0020C, 0, 1, 0, 1);
    addVec(1, 0, 1, 20'h777,   20'h0020C, 0, 1, 0, 1);
    addVec(1, 1, 0, 20'h0,     20'h0020C, 0, 1, 1, 1);
    addVec(0, 1, 0, 20'h0,     20'h00400, 1, 1, 0, 2);
    addVec(0, 1, 0, 20'h0,     20'h00404, 1, 1, 0, 2);
    addVec(0, 1, 0, 20'h0,     20'h00408, 1, 0, 0, 2);
    addVec(1, 1, 1, 20'h80,    20'h0040C, 0, 1, 1, 2);
    addVec(0, 1, 1, 20'h900,   20'h00080, 1, 1, 0, 3);
    addVec(0, 1, 1, 20'h900,   20'h00084, 1, 1, 0, 3);
    addVec(0, 1, 0, 20'h0,     20'h00088, 1, 0, 0, 3);

    modelReset();
    @(negedge clk);
    #1;
    checkOutput("reset_pc", 32'(pc_out), 32'h0);
    checkOutput("reset_flush", 32'(flush_out), 32'h0);
    checkOutput("reset_cnt", 32'(redirect_cnt_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
      checkOutput($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vecs[i].exp_pc));
      checkOutput($sformatf("vec%0d_fetch", i), 32'(fetch_valid_out), 32'(vecs[i].exp_fetch));
      checkOutput($sformatf("vec%0d_flush", i), 32'(flush_out), 32'(vecs[i].exp_flush));
      checkOutput($sformatf("vec%0d_ack", i), 32'(redirect_ack_out), 32'(vecs[i].exp_ack));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(redirect_cnt_out), 32'(vecs[i].exp_cnt));
      stepModel();
    end

    // PC wrap at the top of the address space, then target low-bit masking.
    applyStimulus(0, 1, 1, 20'hFFFFC); stepModel();
    applyStimulus(1, 1, 0, 20'h0);     stepModel();
    applyStimulus(1, 1, 0, 20'h0);     stepModel();
    applyStimulus(0, 1, 0, 20'h0);
    checkOutput("wrap_top_pc", 32'(pc_out), 32'hFFFFC);
    stepModel();
    applyStimulus(1, 1, 0, 20'h0);
    checkOutput("wrap_pc", 32'(pc_out), 32'h0);
    stepModel();
    applyStimulus(0, 1, 1, 20'h203);   stepModel();
    applyStimulus(1, 1, 0, 20'h0);
    checkOutput("mask_pc", 32'(pc_out), 32'h200);
    stepModel();
    applyStimulus(1, 1, 0, 20'h0);     stepModel();

    // Asynchronous reset in the middle of a pending redirect.
    applyStimulus(0, 0, 1, 20'h5554);  stepModel();
    applyStimulus(0, 0, 0, 20'h0);     stepModel();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("hold_rst_pc", 32'(pc_out), 32'h0);
    checkOutput("hold_rst_flush", 32'(flush_out), 32'h0);
    checkOutput("hold_rst_cnt", 32'(redirect_cnt_out), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 20'h0);
    checkOutput("post_rst_pc", 32'(pc_out), 32'h0);
    stepModel();

    // Saturation on the narrow counter instance.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 1, PCW'(32'h1000 + k * 16)); stepModel();
      applyStimulus(1, 1, 0, 20'h0); stepModel();
      applyStimulus(1, 1, 0, 20'h0); stepModel();
    end
    applyStimulus(0, 1, 1, 20'h3000);
    checkOutput("sat_cnt_small", 32'(cnt_small), 32'h3);
    stepModel();
    applyStimulus(0, 1, 0, 20'h0);
    checkOutput("sat_hold_small", 32'(cnt_small), 32'h3);
    checkOutput("sat_wide_cnt", 32'(redirect_cnt_out), 32'd6);
    stepModel();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 5) == 0), PCW'($urandom()));
      stepModel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
